lcd_text_writer: RTL and testbench
==================================

# lcd_text_writer

Character-LCD driver for the game board: owns the HD44780-compatible parallel bus in 8-bit, write-only mode and runs the controller's power-up initialisation. It accepts two 16-character lines from the game logic through a print/available handshake and writes both lines to display RAM. It is the display-side responder to the game state machine's `topline`/`bottomline`/`print` requests.

## Interface
- `CLK_HZ`, 50000000: clock frequency; documentation only, does not change behaviour.
- `E_CYCLES`, 12: cycles `lcd_enable` is held high per byte.
- `CHAR_WAIT`, 2000: post-pulse wait after normal commands and characters (40 us).
- `INIT_WAIT`, 250000: post-pulse wait after each of the first three function-set commands (5 ms).
- `CLEAR_WAIT`, 100000: post-pulse wait after clear-display (2 ms).
- `POWERUP_WAIT`, 1000000: idle time after reset before the first command (20 ms).
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `print` in 1: request to write `topline` and `bottomline`; accepted only while `available`=1.
- `topline` in 128: line-1 text, 8-bit ASCII; bits [127:120] are the leftmost character.
- `bottomline` in 128: line-2 text, same packing.
- `available` out 1: 1 when idle and ready for `print`.
- `lcd_data` out 8: LCD data bus.
- `lcd_regsel` out 1: 0 = command, 1 = character data.
- `lcd_read` out 1: constant 0 (write only).
- `lcd_enable` out 1: LCD E strobe.

## Operation
- Reset (`reset_n`=0 at an edge): `available`=0, `lcd_enable`=0, `lcd_regsel`=0, `lcd_read`=0, `lcd_data`=8'h00. All counters clear and the FSM enters POWERUP. Reset in any state, including mid-byte, aborts the operation and restarts the full initialisation. No partial line is resumed.
- States: POWERUP -> INIT -> IDLE -> WRITE -> IDLE.
- POWERUP: idle for `POWERUP_WAIT` cycles with all outputs at their reset values.
- INIT: send commands in this order: 8'h38, 8'h38, 8'h38 (each followed by `INIT_WAIT`), 8'h38 (`CHAR_WAIT`), 8'h0C (`CHAR_WAIT`), 8'h01 (`CLEAR_WAIT`), 8'h06 (`CHAR_WAIT`). All are sent with `lcd_regsel`=0. Then go to IDLE.
- IDLE: `available`=1, `lcd_enable`=0. On an edge with `print`=1, capture `topline` and `bottomline` into internal registers and go to WRITE.
- Later changes to the inputs do not affect the write in progress.
- `print` while `available`=0 is ignored; it is not queued.
- WRITE: send 34 bytes in order:
  - 8'h80 (command)
  - 16 characters of `topline`, MSB byte first (data)
  - 8'hC0 (command)
  - 16 characters of `bottomline`, MSB byte first (data)
  - Every byte uses `CHAR_WAIT`. Then return to IDLE.
- Byte cycle, three phases:
  - SETUP: 1 cycle. `lcd_data` and `lcd_regsel` driven, `lcd_enable`=0.
  - PULSE: `E_CYCLES` cycles with `lcd_enable`=1.
  - WAIT: the wait count for that byte, with `lcd_enable`=0.
  - `lcd_data` and `lcd_regsel` are stable from SETUP through the end of WAIT.
- Character bytes are passed through unmodified; no ASCII translation.
- Outputs are registered. No combinational path from `print` or the line inputs to any output.

## Timing
- One byte takes 1 + `E_CYCLES` + wait cycles.
- `available` falls on the edge after the accepting edge. It stays 0 for exactly 34 × (1 + `E_CYCLES` + `CHAR_WAIT`) cycles, then rises.
- First byte SETUP begins on the edge after acceptance.
- `lcd_enable` never rises in the same cycle that `lcd_data` or `lcd_regsel` changes.
- Initialisation length = `POWERUP_WAIT` + 7 × (1 + `E_CYCLES`) + 3 × `INIT_WAIT` + 3 × `CHAR_WAIT` + `CLEAR_WAIT`. It is counted from the first edge with `reset_n`=1.
- `available` is 0 throughout initialisation. `print` during initialisation is ignored.
- Wait counters are wide enough for `POWERUP_WAIT`; they saturate and never wrap.

## Test plan
All scenarios use overridden parameters `E_CYCLES`=2, `CHAR_WAIT`=4, `INIT_WAIT`=6, `CLEAR_WAIT`=8, `POWERUP_WAIT`=10.
- Reset/init: release `reset_n` -> `lcd_enable` pulses carry 38,38,38,38,0C,01,06 with `lcd_regsel`=0. `available` rises exactly 69 cycles after the first high `reset_n` edge.
- Print: `print`=1 for one cycle with topline="Welcome to Simon" and bottomline="Press GRN button":
  - Captured stream is 80,'W','e',…,'n',C0,'P',…,'n'.
  - `lcd_regsel`=1 only on the 32 characters.
  - `available` is low for exactly 238 cycles.
- Busy ignore: second `print` with "WRONG GAME OVER!" issued 50 cycles into a write -> stream is unchanged; no second write starts after `available` returns.
- Input change mid-write: alter `topline` after acceptance -> the LCD receives the originally captured text.
- Reset mid-write: drop `reset_n` during character 5 -> next cycle `lcd_enable`=0, `lcd_data`=00, `available`=0, and the full 7-command init replays.
- Strobe hygiene: for every byte, `lcd_data`/`lcd_regsel` are stable from 1 cycle before `lcd_enable` rises until 4 cycles after it falls. `lcd_read`=0 always.

Source files
------------

// File: rtl/lcd_text_writer.sv
// HD44780-compatible character-LCD writer: 8-bit write-only bus, power-up init,
// and two 16-character lines per print request.
module lcd_text_writer #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned E_CYCLES     = 12,
  parameter int unsigned CHAR_WAIT    = 2000,
  parameter int unsigned INIT_WAIT    = 250000,
  parameter int unsigned CLEAR_WAIT   = 100000,
  parameter int unsigned POWERUP_WAIT = 1000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         print,
  input  logic [127:0] topline,
  input  logic [127:0] bottomline,
  output logic         available,
  output logic [7:0]   lcd_data,
  output logic         lcd_regsel,
  output logic         lcd_read,
  output logic         lcd_enable
);

  localparam int unsigned MAX_A   = (POWERUP_WAIT > INIT_WAIT) ? POWERUP_WAIT : INIT_WAIT;
  localparam int unsigned MAX_B   = (CLEAR_WAIT > CHAR_WAIT) ? CLEAR_WAIT : CHAR_WAIT;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_ALL = (MAX_C > E_CYCLES) ? MAX_C : E_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);
  localparam int unsigned IDX_W   = 6;

  if (CLK_HZ == 0) begin : g_clk_hz_check
    $error("CLK_HZ must be nonzero");
  end

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_IDLE,
    ST_LATCH
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               init_mode, init_mode_n;
  logic [127:0]       top_q, bot_q;
  logic               capture;
  logic [7:0]         data_n;
  logic               regsel_n, enable_n, available_n;
  logic [CNT_W-1:0]   wait_m1;
  logic               last_byte;

  assign lcd_read = 1'b0;

  // Byte {regsel, data} for position i of the init or write sequence.
  function automatic logic [8:0] byte_of(input logic init, input logic [IDX_W-1:0] i);
    logic [3:0] ch;
    logic [8:0] b;
    ch = 4'(i - 6'd1);
    if (init) begin
      case (i)
        6'd0, 6'd1, 6'd2, 6'd3: b = {1'b0, 8'h38};
        6'd4:                   b = {1'b0, 8'h0C};
        6'd5:                   b = {1'b0, 8'h01};
        default:                b = {1'b0, 8'h06};
      endcase
    end else if (i == 6'd0) begin
      b = {1'b0, 8'h80};
    end else if (i <= 6'd16) begin
      b = {1'b1, top_q[{4'(4'd15 - ch), 3'b000} +: 8]};
    end else if (i == 6'd17) begin
      b = {1'b0, 8'hC0};
    end else begin
      ch = 4'(i - 6'd18);
      b  = {1'b1, bot_q[{4'(4'd15 - ch), 3'b000} +: 8]};
    end
    return b;
  endfunction

  // Post-pulse wait length (minus one) and end-of-sequence flag for the current byte.
  always_comb begin
    wait_m1   = CNT_W'(CHAR_WAIT - 1);
    last_byte = (idx == 6'd33);
    if (init_mode) begin
      last_byte = (idx == 6'd6);
      if (idx < 6'd3)       wait_m1 = CNT_W'(INIT_WAIT - 1);
      else if (idx == 6'd5) wait_m1 = CNT_W'(CLEAR_WAIT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_POWERUP;
      cnt        <= '0;
      idx        <= '0;
      init_mode  <= 1'b1;
      top_q      <= '0;
      bot_q      <= '0;
      available  <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_regsel <= 1'b0;
      lcd_enable <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      init_mode  <= init_mode_n;
      available  <= available_n;
      lcd_data   <= data_n;
      lcd_regsel <= regsel_n;
      lcd_enable <= enable_n;
      if (capture) begin
        top_q <= topline;
        bot_q <= bottomline;
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    idx_n       = idx;
    init_mode_n = init_mode;
    capture     = 1'b0;
    data_n      = lcd_data;
    regsel_n    = lcd_regsel;

    unique case (state)
      ST_POWERUP: begin
        if (cnt >= CNT_W'(POWERUP_WAIT)) begin
          state_n     = ST_SETUP;
          idx_n       = '0;
          init_mode_n = 1'b1;
        end
      end
      ST_SETUP: begin
        state_n = ST_PULSE;
        cnt_n   = '0;
      end
      ST_PULSE: begin
        if (cnt >= CNT_W'(E_CYCLES - 1)) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt >= wait_m1) begin
          cnt_n = '0;
          if (last_byte) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_SETUP;
            idx_n   = idx + 6'd1;
          end
        end
      end
      ST_IDLE: begin
        if (print) begin
          state_n     = ST_LATCH;
          capture     = 1'b1;
          init_mode_n = 1'b0;
          idx_n       = '0;
        end
      end
      ST_LATCH: begin
        state_n = ST_SETUP;
        cnt_n   = '0;
      end
      default: state_n = ST_POWERUP;
    endcase

    // Data and regsel only change when entering SETUP, so E never rises on a change.
    if (state_n == ST_SETUP) {regsel_n, data_n} = byte_of(init_mode_n, idx_n);
    enable_n    = (state_n == ST_PULSE);
    available_n = (state_n == ST_IDLE) || (state_n == ST_LATCH);
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Randomized self-checking bench for lcd_text_writer against a byte-stream model.
module tb_lcd_text_writer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         print;
  logic [127:0] topline, bottomline;
  logic         available;
  logic [7:0]   lcd_data;
  logic         lcd_regsel, lcd_read, lcd_enable;

  int checks = 0;
  int errors = 0;

  logic [8:0] cap[$];
  logic [8:0] exp_q[$];

  lcd_text_writer #(
    .CLK_HZ(50000000), .E_CYCLES(2), .CHAR_WAIT(4), .INIT_WAIT(6),
    .CLEAR_WAIT(8), .POWERUP_WAIT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .print(print), .topline(topline),
    .bottomline(bottomline), .available(available), .lcd_data(lcd_data),
    .lcd_regsel(lcd_regsel), .lcd_read(lcd_read), .lcd_enable(lcd_enable)
  );

  always #5 clk = ~clk;

  // Bus monitor: captures each strobed byte and checks data/regsel stability around E.
  logic       m_prev_en = 1'b0;
  logic [8:0] m_prev = '0;
  int         m_post = 0;
  always @(negedge clk) begin
    logic [8:0] cur;
    checks++;
    if (lcd_read !== 1'b0) begin
      errors++;
      $display("FAIL lcd_read got %b want 0", lcd_read);
    end
    cur = {lcd_regsel, lcd_data};
    if (!reset_n) begin
      m_prev_en = 1'b0;
      m_post    = 0;
    end else begin
      if (m_prev_en && !lcd_enable) m_post = 4;
      if (lcd_enable && !m_prev_en) begin
        cap.push_back(cur);
        checks++;
        if (cur !== m_prev) begin
          errors++;
          $display("FAIL strobe_setup got %h want %h", cur, m_prev);
        end
      end else if (lcd_enable || m_post > 0) begin
        checks++;
        if (cur !== m_prev) begin
          errors++;
          $display("FAIL strobe_hold got %h want %h", cur, m_prev);
        end
        if (!lcd_enable) m_post--;
      end
      m_prev_en = lcd_enable;
    end
    m_prev = cur;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rand_text();
    logic [127:0] t;
    for (int i = 0; i < 16; i++) t[8*i +: 8] = 8'($urandom_range(32, 126));
    return t;
  endfunction

  task automatic model_init();
    logic [7:0] cmds[7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    exp_q.delete();
    foreach (cmds[i]) exp_q.push_back({1'b0, cmds[i]});
  endtask

  task automatic model_write(input logic [127:0] t, input logic [127:0] b);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, t[127-8*i -: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, b[127-8*i -: 8]});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!available && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!available) begin
      errors++;
      $display("FAIL wait_idle got available=%b want 1", available);
    end
  endtask

  // Present a one-cycle print; returns at the negedge after the accepting edge.
  task automatic do_print(input logic [127:0] t, input logic [127:0] b);
    topline    = t;
    bottomline = b;
    print      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    print = 1'b0;
  endtask

  // Counts cycles available stays low after the post-acceptance cycle.
  task automatic measure_busy(output int n);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (available) break;
      n++;
    end
  endtask

  // Expects reset_n just released; next edge is the first high edge.
  task automatic check_init(input string tag);
    @(posedge clk);
    for (int j = 0; j <= 69; j++) begin
      @(negedge clk);
      checks++;
      if (available !== (j == 69)) begin
        errors++;
        $display("FAIL %s_avail cycle %0d got %b want %b", tag, j, available, (j == 69));
      end
    end
    print = 1'b0;
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len got %0d want %0d", tag, cap.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_byte%0d got %h want %h", tag, i, cap[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    print      = 1'b1;
    topline    = rand_text();
    bottomline = rand_text();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({available, lcd_enable, lcd_regsel, lcd_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got av=%b en=%b rs=%b d=%h want all 0",
               available, lcd_enable, lcd_regsel, lcd_data);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    cap.delete();
    model_init();
    check_init("init");
    repeat (20) @(negedge clk);
    checks++;
    if (!available || cap.size() != 7) begin
      errors++;
      $display("FAIL init_print_ignored got av=%b bytes=%0d want 1 7", available, cap.size());
    end
  endtask

  task automatic run_write(input string tag, input logic [127:0] t, input logic [127:0] b,
                           input int busy_at, input bit scramble);
    int n;
    wait_idle();
    cap.delete();
    model_write(t, b);
    do_print(t, b);
    checks++;
    if (available !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept_cycle got %b want 1", tag, available);
    end
    if (busy_at > 0) begin
      repeat (busy_at - 1) @(negedge clk);
      do_print("WRONG GAME OVER!", rand_text());
    end
    if (scramble) begin
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        topline    = rand_text();
        bottomline = rand_text();
      end
    end
    measure_busy(n);
    n = n + busy_at + (scramble ? 100 : 0);
    checks++;
    if (n != 238) begin
      errors++;
      $display("FAIL %s_busy got %0d want 238", tag, n);
    end
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len got %0d want %0d", tag, cap.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_byte%0d got %h want %h", tag, i, cap[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_print();
    run_write("print", "Welcome to Simon", "Press GRN button", 0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    int bad = 0;
    run_write("busy", "Welcome to Simon", "Press GRN button", 50, 1'b0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!available) bad++;
    end
    checks++;
    if (bad != 0 || cap.size() != 34) begin
      errors++;
      $display("FAIL busy_no_requeue got low=%0d bytes=%0d want 0 34", bad, cap.size());
    end
  endtask

  task automatic test_input_change();
    run_write("inchg", rand_text(), rand_text(), 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) run_write($sformatf("b2b%0d", k), rand_text(), rand_text(), 0, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    wait_idle();
    cap.delete();
    do_print(rand_text(), rand_text());
    while (cap.size() < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({available, lcd_enable, lcd_regsel, lcd_data} !== 11'd0) begin
      errors++;
      $display("FAIL midreset_outputs got av=%b en=%b rs=%b d=%h want all 0",
               available, lcd_enable, lcd_regsel, lcd_data);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    cap.delete();
    model_init();
    check_init("reinit");
  endtask

  initial begin
    print      = 1'b0;
    reset_n    = 1'b0;
    topline    = '0;
    bottomline = '0;
    test_reset();
    test_print();
    test_busy_ignore();
    test_input_change();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
